fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the main decoder. It holds the program counter, fetches words from instruction memory over a req/ack handshake, and presents the instruction, including its `OpCode` and `Funct` fields, to the decoder. It then computes the next PC from the decoder's `Branch`/`Jump` outputs and the ALU zero flag. A downstream stall input freezes the presented instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; equals `pc` whenever `imem_req`=1.
- `imem_rdata`  in  32: instruction word; sampled only in the ack cycle.
- `imem_ack`  in  1: memory has the word; ignored unless `imem_req`=1.
- `instr`  out  32: registered instruction.
- `OpCode`  out  6: `instr[31:26]`.
- `Funct`  out  6: `instr[5:0]`.
- `instr_valid`  out  1: `instr` is valid and being executed.
- `pc`  out  32: address of current/pending instruction.
- `pc_plus4`  out  32: `pc + 4`, modulo 2^32.
- `stall`  in  1: downstream cannot retire the current instruction.
- `Branch`  in  1: from decoder; a conditional branch is in flight.
- `Jump`  in  1: from decoder; an unconditional jump is in flight.
- `Zero`  in  1: ALU branch-condition result; 1 means the branch is taken.
- `retire_cnt`  out  32: count of retired instructions; wraps.

## Operation
- Two-state FSM:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ack`: `instr`<=`imem_rdata`, go to EXEC.
    - Otherwise remain; `pc` and `imem_addr` stay stable.
  - EXEC: `instr_valid`=1, `imem_req`=0.
    - On `stall`=1: hold everything.
    - On `stall`=0: retire, i.e. `pc`<=npc, `retire_cnt`+1, go to FETCH.
- npc priority:
  - `Jump`=1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}. This applies even if `Branch`=1; the decoder asserts both for J.
  - else `Branch`&`Zero`: `pc_plus4` + sign-extended {`instr[15:0]`, 2'b00} (18-bit value extended to 32).
  - else: `pc_plus4`.
- `Branch`/`Jump`/`Zero` are sampled only in the EXEC retire cycle and ignored in FETCH.
- Arithmetic: all 32-bit, modulo 2^32, with no overflow flag. `pc`=32'hFFFF_FFFC gives `pc_plus4`=0. npc[1:0] is always 2'b00.
- `instr` retains its last value in FETCH. `instr_valid`=0 marks it stale, and downstream must not write state.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `pc`=`RESET_PC`
  - `instr`=0
  - `instr_valid`=0
  - `retire_cnt`=0
  - state=FETCH
  - `imem_req`=0 while `rst`=1, then 1 from the first cycle with `rst`=0.
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state and `pc`; no combinational path from `imem_ack`.
- Minimum throughput is one instruction per 2 cycles (ack in the first FETCH cycle, no stall). Each memory wait cycle or stall cycle adds one cycle.
- `rst` mid-FETCH with ack in the same cycle: ack ignored, `instr` cleared, PC reset.
- `rst` mid-EXEC: instruction not retired, counter not incremented.
- `rst` overrides `stall` and `imem_ack`.
- `stall` in FETCH has no effect.
- `imem_ack` in EXEC is ignored.

## Test plan
- Reset, then ack the first FETCH cycle with 32'h3408_0005 (ori), `stall`=0:
  - `imem_addr`=32'h3000 and `instr_valid` rises one cycle after the ack.
  - `pc`=32'h3004 on the following FETCH.
  - `retire_cnt`=1.
- BEQ 32'h1000_FFFF at `pc`=32'h3008 with `Branch`=1, `Zero`=1 → next `imem_addr`=32'h3008.
- Same BEQ with `Zero`=0 → next `imem_addr`=32'h300C.
- J 32'h0800_0C10 at 32'h3010 with `Jump`=1 and `Branch`=1 → npc=32'h0000_3040.
- `imem_ack` delayed 3 cycles, then `stall` held 2 cycles in EXEC:
  - `imem_addr` is constant throughout the wait.
  - `instr` and `pc` are frozen during the stall.
  - `retire_cnt` increments exactly once.
- `pc` forced by a jump to 32'hFFFF_FFFC with no branch → next `pc`=0.
- `rst` asserted in the ack cycle → all outputs at reset values and `imem_addr`=`RESET_PC` on restart.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the main decoder. Holds the program counter,
// fetches one word per instruction over a req/ack handshake, presents the
// registered instruction (with its OpCode/Funct fields) and, when the
// instruction retires, computes the next PC from Jump/Branch/Zero.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and address (address == pc)
//   imem_rdata/imem_ack returned word and its qualifier
//   instr, OpCode, Funct registered instruction and its decoded fields
//   instr_valid         instr is current and being executed
//   pc, pc_plus4        current instruction address and its successor
//   stall               downstream cannot retire the current instruction
//   Branch, Jump, Zero  control-flow inputs, sampled in the retire cycle
//   retire_cnt          wrapping count of retired instructions
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] retire_cnt
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        load_instr;
  logic        retire;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] npc;

  // Next-PC candidates. Jump keeps the 256 MB region of pc+4; the branch
  // offset is a word offset, so {imm16, 2'b00} is sign-extended from bit 17.
  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Jump wins over Branch: the decoder raises both for J.
  assign npc = Jump            ? jump_target :
               (Branch && Zero) ? (pc_plus4 + branch_offset) :
                                 pc_plus4;

  assign OpCode    = instr[31:26];
  assign Funct     = instr[5:0];
  assign imem_addr = pc;

  // NOTE: every signal driven here gets a default first so that no path
  // through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    load_instr  = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        // Request is dropped while reset is held so the memory never sees a
        // fetch that is about to be discarded. imem_ack only steers state.
        imem_req = !rst;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      instr      <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      if (load_instr) instr <= imem_rdata;
      if (retire) begin
        pc         <= npc;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .stall      (stall),
    .Branch     (Branch),
    .Jump       (Jump),
    .Zero       (Zero),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ack a word in the current FETCH cycle, check it is presented, then retire
  // it with the given control-flow inputs. Ends in the next FETCH cycle.
  task automatic run_instr(input string tag, input logic [31:0] word,
                           input logic br, input logic jmp, input logic zero);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, word);
    Branch = br;
    Jump   = jmp;
    Zero   = zero;
    tick();
    Branch = 1'b0;
    Jump   = 1'b0;
    Zero   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    Zero       = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_pc",    pc,                     32'h0000_3000);
    check("rst_instr", instr,                  32'h0);
    check("rst_valid", {31'd0, instr_valid},   32'd0);
    check("rst_cnt",   retire_cnt,             32'd0);
    check("rst_req",   {31'd0, imem_req},      32'd0);
    rst = 1'b0;
    #1;
    check("first_req",  {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr,         32'h0000_3000);

    // ori, acked in first FETCH cycle
    imem_ack   = 1'b1;
    imem_rdata = 32'h3408_0005;
    tick();
    imem_ack = 1'b0;
    check("ori_valid",  {31'd0, instr_valid}, 32'd1);
    check("ori_opcode", {26'd0, OpCode},      32'h0D);
    check("ori_funct",  {26'd0, Funct},       32'h05);
    check("ori_req",    {31'd0, imem_req},    32'd0);
    check("ori_pc",     pc,                   32'h0000_3000);
    tick();
    check("ori_npc",    imem_addr,            32'h0000_3004);
    check("ori_cnt",    retire_cnt,           32'd1);
    check("ori_fetch",  {31'd0, instr_valid}, 32'd0);
    check("ori_stale",  instr,                32'h3408_0005);

    run_instr("nop0", 32'h0, 1'b0, 1'b0, 1'b0);
    check("nop0_pc", pc, 32'h0000_3008);

    // BEQ offset -1 word: 0x300C - 4 = 0x3008
    run_instr("beq_t", 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
    check("beq_t_addr", imem_addr, 32'h0000_3008);
    run_instr("beq_nt", 32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
    check("beq_nt_addr", imem_addr, 32'h0000_300C);
    run_instr("nop1", 32'h0, 1'b0, 1'b0, 1'b0);
    check("nop1_pc", pc, 32'h0000_3010);

    // J with Branch also high: target {0, 0x0C10, 00} = 0x3040
    run_instr("j", 32'h0800_0C10, 1'b1, 1'b1, 1'b1);
    check("j_pc",  pc,         32'h0000_3040);
    check("j_cnt", retire_cnt, 32'd6);

    // Three wait cycles (stall in FETCH must not matter), then a 2-cycle stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_addr",  imem_addr,            32'h0000_3040);
      check("wait_req",   {31'd0, imem_req},    32'd1);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    tick();
    check("wait_load", instr, 32'h0000_0020);
    // ack in EXEC must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_instr", instr,                32'h0000_0020);
      check("stall_pc",    pc,                   32'h0000_3040);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_cnt",   retire_cnt,           32'd6);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    tick();
    check("stall_npc", pc,         32'h0000_3044);
    check("stall_cnt", retire_cnt, 32'd7);

    // Jump to 0 (region of 0x3048), then branch back -2 words to 0xFFFF_FFFC
    run_instr("j0", 32'h0800_0000, 1'b0, 1'b1, 1'b0);
    check("j0_pc", pc, 32'h0);
    run_instr("bwrap", 32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
    check("bwrap_pc",  pc,       32'hFFFF_FFFC);
    check("bwrap_pc4", pc_plus4, 32'h0);
    run_instr("wrap", 32'h0, 1'b0, 1'b0, 1'b0);
    check("wrap_pc",  pc,         32'h0);
    check("wrap_cnt", retire_cnt, 32'd10);

    // Reset coinciding with an ack in FETCH
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstack_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("rstack_instr", instr,                32'h0);
    check("rstack_valid", {31'd0, instr_valid}, 32'd0);
    check("rstack_pc",    pc,                   32'h0000_3000);
    check("rstack_cnt",   retire_cnt,           32'd0);
    rst      = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("restart_req",  {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr,         32'h0000_3000);

    // Reset in EXEC: no retire, no count
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("rstex_valid0", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstex_pc",    pc,                   32'h0000_3000);
    check("rstex_cnt",   retire_cnt,           32'd0);
    check("rstex_valid", {31'd0, instr_valid}, 32'd0);
    check("rstex_instr", instr,                32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
